// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type, parity encodings and legal data-width bounds
// for the parametrised UART transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int DATA_WIDTH_MIN = 5;
    localparam int DATA_WIDTH_MAX = 9;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous holding FIFO for the UART transmitter, async active-low reset.
// Pointers carry one extra wrap bit so full and empty are distinguishable without a counter.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wrPtr_q, rdPtr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wrEn, rdEn;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
    end

    assign empty_o = (wrPtr_q == rdPtr_q);
    assign full_o  = (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]) && (wrPtr_q[AW] != rdPtr_q[AW]);
    assign rdEn    = pop_i && !empty_o;
    // A pop on the same edge frees the slot, so a push into a full FIFO is still legal then.
    assign wrEn    = push_i && (!full_o || rdEn);
    assign data_o  = mem_q[rdPtr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (wrEn) wrPtr_q <= wrPtr_q + 1'b1;
            if (rdEn) rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) mem_q[wrPtr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: UART transmitter with configurable width, runtime prescaler, parity, 1/2 stop bits.
// Define UART_TX_FIFO_EN to insert a FIFO_DEPTH-entry holding FIFO for back-to-back frames.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     P_Data,
    input  logic                      Data_valid,
    output logic                      Data_ready,
    input  logic                      Par_en,
    input  logic                      Par_type,
    input  logic                      Stop2,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      busy
);
    localparam int IDXW = $clog2(DATA_WIDTH);

    uart_state_e               state_q;
    logic [PRESCALE_WIDTH-1:0] baud_q, presc_q, presc_d;
    logic [IDXW-1:0]           bitIdx_q;
    logic                      stopCnt_q, parEn_q, parType_q, stop2_q;
    logic [DATA_WIDTH-1:0]     data_q, word_d;
    logic                      txOut_q, busy_q;
    logic                      lineBit, bitEnd, lastStopEnd, takeWord;

    if (DATA_WIDTH < DATA_WIDTH_MIN || DATA_WIDTH > DATA_WIDTH_MAX || FIFO_DEPTH < 2) begin : g_bad_param
        $error("uart_tx_param: illegal DATA_WIDTH or FIFO_DEPTH");
    end

    assign presc_d     = (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;
    assign bitEnd      = (baud_q == presc_q - PRESCALE_WIDTH'(1));
    assign lastStopEnd = (state_q == STOP) && bitEnd && (stopCnt_q == stop2_q);

`ifdef UART_TX_FIFO_EN
    logic fifoFull, fifoEmpty;

    uart_tx_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (Data_valid),
        .data_i  (P_Data),
        .pop_i   (takeWord),
        .data_o  (word_d),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    assign Data_ready = !fifoFull;
    // Chaining straight from the last stop bit into START keeps frames gap-free.
    assign takeWord   = !fifoEmpty && ((state_q == IDLE) || lastStopEnd);
`else
    assign word_d     = P_Data;
    assign Data_ready = (state_q == IDLE);
    assign takeWord   = Data_valid && (state_q == IDLE);
`endif

    always_comb begin
        lineBit = 1'b1;
        unique case (state_q)
            START:   lineBit = 1'b0;
            DATA:    lineBit = data_q[bitIdx_q];
            PARITY:  lineBit = (^data_q) ^ (parType_q == PAR_ODD);
            default: lineBit = 1'b1;
        endcase
    end

    // Outputs trail the state by one register stage, so the line and busy follow the FSM by a cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            presc_q   <= PRESCALE_WIDTH'(1);
            bitIdx_q  <= '0;
            stopCnt_q <= 1'b0;
            parEn_q   <= 1'b0;
            parType_q <= PAR_EVEN;
            stop2_q   <= 1'b0;
            data_q    <= '0;
            txOut_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            txOut_q <= lineBit;
            busy_q  <= (state_q != IDLE);
            if (takeWord) begin
                state_q   <= START;
                data_q    <= word_d;
                presc_q   <= presc_d;
                parEn_q   <= Par_en;
                parType_q <= Par_type;
                stop2_q   <= Stop2;
                baud_q    <= '0;
                bitIdx_q  <= '0;
                stopCnt_q <= 1'b0;
            end else if (state_q != IDLE) begin
                if (!bitEnd) begin
                    baud_q <= baud_q + 1'b1;
                end else begin
                    baud_q <= '0;
                    unique case (state_q)
                        START: state_q <= DATA;
                        DATA: begin
                            if (bitIdx_q == IDXW'(DATA_WIDTH - 1)) begin
                                state_q <= parEn_q ? PARITY : STOP;
                            end else begin
                                bitIdx_q <= bitIdx_q + 1'b1;
                            end
                        end
                        PARITY: state_q <= STOP;
                        STOP: begin
                            if (stopCnt_q == stop2_q) state_q <= IDLE;
                            else                      stopCnt_q <= 1'b1;
                        end
                        default: state_q <= IDLE;
                    endcase
                end
            end
        end
    end

    assign TX_OUT = txOut_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param: directed self-checking bench for uart_tx_param (8-bit and 5-bit instances).
// With UART_TX_FIFO_EN defined it also checks back-to-back frames through the holding FIFO.
module tb_uart_tx_param;

    logic        clk;
    logic        rst;
    logic [7:0]  pData8;
    logic [4:0]  pData5;
    logic        valid8, valid5;
    logic        ready8, ready5;
    logic        parEn, parType, stop2;
    logic [15:0] prescale;
    logic        tx8, tx5, busy8, busy5;

    int testsRun  = 0;
    int failCount = 0;

`ifdef UART_TX_FIFO_EN
    localparam int LAT_EXP = 2;
`else
    localparam int LAT_EXP = 1;
`endif

    uart_tx_param #(.DATA_WIDTH(8), .PRESCALE_WIDTH(16), .FIFO_DEPTH(4)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .P_Data     (pData8),
        .Data_valid (valid8),
        .Data_ready (ready8),
        .Par_en     (parEn),
        .Par_type   (parType),
        .Stop2      (stop2),
        .Prescale   (prescale),
        .TX_OUT     (tx8),
        .busy       (busy8)
    );

    uart_tx_param #(.DATA_WIDTH(5), .PRESCALE_WIDTH(16), .FIFO_DEPTH(4)) dut5 (
        .clk        (clk),
        .rst        (rst),
        .P_Data     (pData5),
        .Data_valid (valid5),
        .Data_ready (ready5),
        .Par_en     (parEn),
        .Par_type   (parType),
        .Stop2      (stop2),
        .Prescale   (prescale),
        .TX_OUT     (tx5),
        .busy       (busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Expected line level for bit slot idx of a frame: start, data LSB first, optional parity, stop(s).
    function automatic logic expBit(input int idx, input logic [8:0] word, input int dw,
                                    input logic pe, input logic parBit);
        if (idx == 0) return 1'b0;
        if (idx <= dw) return word[idx-1];
        if (pe && idx == dw + 1) return parBit;
        return 1'b1;
    endfunction

    task automatic applyStimulus(input int sel, input logic [8:0] word, input logic pe, input logic pt,
                                 input logic s2, input logic [15:0] presc, input string tag);
        int k;
        @(negedge clk);
        parEn    = pe;
        parType  = pt;
        stop2    = s2;
        prescale = presc;
        if (sel == 0) begin pData8 = word[7:0]; valid8 = 1'b1; end
        else           begin pData5 = word[4:0]; valid5 = 1'b1; end
        k = 0;
        while (!((sel != 0) ? ready5 : ready8) && k < 300) begin
            @(negedge clk);
            k++;
        end
        checkOutput({tag, "_ready"}, (sel != 0) ? ready5 : ready8, 1);
        @(posedge clk);
        @(negedge clk);
        valid8 = 1'b0;
        valid5 = 1'b0;
`ifndef UART_TX_FIFO_EN
        checkOutput({tag, "_readyDrop"}, (sel != 0) ? ready5 : ready8, 0);
`endif
    endtask

    task automatic checkFrame(input int sel, input logic [8:0] word, input int dw, input logic pe,
                              input logic parBit, input logic s2, input int presc, input string tag);
        int p, frameLen, lat, waveErr, busyCnt, readyLow;
        p        = (presc == 0) ? 1 : presc;
        frameLen = p * (2 + dw + int'(pe) + int'(s2));
        lat = 0; waveErr = 0; busyCnt = 0; readyLow = 0;
        while (!((sel != 0) ? busy5 : busy8) && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        checkOutput({tag, "_latency"}, lat, LAT_EXP);
        // Disturb the configuration mid-frame; the frame in flight must keep its latched settings.
        parEn    = ~pe;
        stop2    = ~s2;
        parType  = ~parType;
        prescale = 16'(presc + 5);
        for (int c = 0; c < frameLen; c++) begin
            if (c > 0) @(negedge clk);
            if (((sel != 0) ? tx5 : tx8) !== expBit(c / p, word, dw, pe, parBit)) waveErr++;
            if ((sel != 0) ? busy5 : busy8) busyCnt++;
            if (!((sel != 0) ? ready5 : ready8)) readyLow++;
        end
        checkOutput({tag, "_wave"}, waveErr, 0);
        checkOutput({tag, "_busyLen"}, busyCnt, frameLen);
`ifndef UART_TX_FIFO_EN
        checkOutput({tag, "_readyLow"}, readyLow, frameLen - 1);
`endif
        @(negedge clk);
        checkOutput({tag, "_idle"}, {30'd0, (sel != 0) ? busy5 : busy8, (sel != 0) ? tx5 : tx8}, 32'h1);
    endtask

`ifdef UART_TX_FIFO_EN
    logic [7:0] fifoWords [5];
`endif

    initial begin
        rst = 1'b0; valid8 = 1'b0; valid5 = 1'b0;
        pData8 = '0; pData5 = '0;
        parEn = 1'b0; parType = 1'b0; stop2 = 1'b0; prescale = 16'd1;

        // Reset values before any clocked activity has been released.
        repeat (2) @(negedge clk);
        checkOutput("reset_tx8",    tx8,    1);
        checkOutput("reset_busy8",  busy8,  0);
        checkOutput("reset_ready8", ready8, 1);
        checkOutput("reset_tx5",    tx5,    1);
        rst = 1'b1;
        @(negedge clk);

        // 8-bit frames: word, par_en, par_type, stop2, prescale, hand-computed parity bit.
        applyStimulus(0, 9'h0A5, 1'b1, 1'b0, 1'b0, 16'd1, "a5_even_p1");
        checkFrame(0, 9'h0A5, 8, 1'b1, 1'b0, 1'b0, 1, "a5_even_p1");
        applyStimulus(0, 9'h0A5, 1'b1, 1'b1, 1'b0, 16'd16, "a5_odd_p16");
        checkFrame(0, 9'h0A5, 8, 1'b1, 1'b1, 1'b0, 16, "a5_odd_p16");
        applyStimulus(0, 9'h000, 1'b0, 1'b0, 1'b1, 16'd4, "zero_stop2_p4");
        checkFrame(0, 9'h000, 8, 1'b0, 1'b0, 1'b1, 4, "zero_stop2_p4");
        applyStimulus(0, 9'h03C, 1'b0, 1'b0, 1'b0, 16'd0, "presc0");
        checkFrame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 0, "presc0");
        applyStimulus(0, 9'h05A, 1'b1, 1'b1, 1'b1, 16'd3, "5a_odd_stop2");
        checkFrame(0, 9'h05A, 8, 1'b1, 1'b1, 1'b1, 3, "5a_odd_stop2");

        // 5-bit frames.
        applyStimulus(1, 9'h01F, 1'b1, 1'b0, 1'b0, 16'd2, "w5_1f_even");
        checkFrame(1, 9'h01F, 5, 1'b1, 1'b1, 1'b0, 2, "w5_1f_even");
        applyStimulus(1, 9'h00B, 1'b1, 1'b1, 1'b1, 16'd3, "w5_0b_odd");
        checkFrame(1, 9'h00B, 5, 1'b1, 1'b0, 1'b1, 3, "w5_0b_odd");

        // Abort mid-DATA with an asynchronous reset, then send a fresh frame.
        applyStimulus(0, 9'h000, 1'b0, 1'b0, 1'b0, 16'd8, "abort");
        repeat (20) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("abort_tx",    tx8,    1);
        checkOutput("abort_busy",  busy8,  0);
        checkOutput("abort_ready", ready8, 1);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(0, 9'h081, 1'b1, 1'b0, 1'b0, 16'd2, "after_reset");
        checkFrame(0, 9'h081, 8, 1'b1, 1'b0, 1'b0, 2, "after_reset");

`ifdef UART_TX_FIFO_EN
        fifoWords[0] = 8'h01; fifoWords[1] = 8'h80; fifoWords[2] = 8'hC3;
        fifoWords[3] = 8'h5A; fifoWords[4] = 8'hFF;
        @(negedge clk);
        parEn = 1'b0; parType = 1'b0; stop2 = 1'b0; prescale = 16'd2;
        fork
            begin : pushSide
                int w;
                for (int k = 0; k < 5; k++) begin
                    pData8 = fifoWords[k];
                    valid8 = 1'b1;
                    w = 0;
                    while (!ready8 && w < 400) begin
                        @(negedge clk);
                        w++;
                    end
                    @(posedge clk);
                    @(negedge clk);
                end
                valid8 = 1'b0;
                checkOutput("fifo_fullReady", ready8, 0);
            end
            begin : lineSide
                int m, waveErr, busyCnt;
                m = 0; waveErr = 0; busyCnt = 0;
                while (!busy8 && m < 40) begin
                    @(negedge clk);
                    m++;
                end
                checkOutput("fifo_start", busy8, 1);
                for (int c = 0; c < 100; c++) begin
                    if (c > 0) @(negedge clk);
                    if (tx8 !== expBit((c % 20) / 2, {1'b0, fifoWords[c / 20]}, 8, 1'b0, 1'b0)) waveErr++;
                    if (busy8) busyCnt++;
                end
                checkOutput("fifo_wave", waveErr, 0);
                checkOutput("fifo_busyLen", busyCnt, 100);
                @(negedge clk);
                checkOutput("fifo_idle", {30'd0, busy8, tx8}, 32'h1);
            end
        join
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
